// File: rtl/restoring_divider_seq.sv
`default_nettype none
// ============================================================================
// Module   : restoring_divider_seq
// Purpose  : Sequential unsigned restoring divider. Each RUN cycle does one
//            trial subtract: the partial remainder is shifted left, the
//            dividend MSB is brought in, and the divisor is subtracted
//            (borrow semantics match the upstream a - b -> diff/Bout
//            subtractor). The cycle produces one quotient bit. The result is
//            returned over a valid/ready handshake.
// Ports    : clk, rst        - rising-edge clock, synchronous active-high reset
//            in_valid        - dividend/divisor valid
//            in_ready        - idle, operands can be accepted
//            dividend        - unsigned dividend  [WIDTH]
//            divisor         - unsigned divisor   [WIDTH]
//            out_valid       - quotient/remainder valid
//            out_ready       - consumer accepts the result
//            quotient        - unsigned quotient  [WIDTH]
//            remainder       - unsigned remainder [WIDTH]
//            div_by_zero     - divisor was zero (only with DIVZERO_CHECK_EN)
// Config   : DIVZERO_CHECK_EN - when defined, a zero divisor goes straight to
//            DONE with quotient = all ones, remainder = dividend and the
//            div_by_zero flag set. When undefined, a zero divisor runs the
//            normal sequence and div_by_zero is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module restoring_divider_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int              CW         = $clog2(WIDTH);
    localparam logic [1:0]      S_IDLE     = 2'd0;
    localparam logic [1:0]      S_RUN      = 2'd1;
    localparam logic [1:0]      S_DONE     = 2'd2;
    localparam logic [CW-1:0]   C_CNT_LOAD = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_dq;        // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH:0]   r_p;         // partial remainder, one guard bit
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    // Trial subtract, one bit wider than the operands so the top bit is the borrow
    logic [WIDTH:0]   w_pshift;
    logic [WIDTH+1:0] w_sub;
    logic             w_borrow;
    logic [WIDTH:0]   w_p_nxt;
    logic [WIDTH-1:0] w_dq_nxt;

    assign w_pshift = {r_p[WIDTH-1:0], r_dq[WIDTH-1]};
    assign w_sub    = {1'b0, w_pshift} - {2'b00, r_divisor};
    assign w_borrow = w_sub[WIDTH+1];
    // Borrow means the divisor did not fit: restore the shifted value
    assign w_p_nxt  = w_borrow ? w_pshift : w_sub[WIDTH:0];
    assign w_dq_nxt = {r_dq[WIDTH-2:0], ~w_borrow};

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
`ifdef DIVZERO_CHECK_EN
                    if (divisor == '0) w_state_nxt = S_DONE;
                    else               w_state_nxt = S_RUN;
`else
                    w_state_nxt = S_RUN;
`endif
                end
            end
            S_RUN:   if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef DIVZERO_CHECK_EN
    logic r_dbz;
    assign div_by_zero = r_dbz;
`else
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dq        <= '0;
            r_divisor   <= '0;
            r_p         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
`ifdef DIVZERO_CHECK_EN
            r_dbz       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_dq      <= dividend;
                        r_divisor <= divisor;
                        r_p       <= '0;
                        r_cnt     <= C_CNT_LOAD;
`ifdef DIVZERO_CHECK_EN
                        r_dbz     <= (divisor == '0);
                        // Zero divisor skips RUN, so publish the result here
                        if (divisor == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                        end
`endif
                    end
                end
                S_RUN: begin
                    r_p  <= w_p_nxt;
                    r_dq <= w_dq_nxt;
                    if (r_cnt == '0) begin
                        r_quotient  <= w_dq_nxt;
                        r_remainder <= w_p_nxt[WIDTH-1:0];
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_restoring_divider_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_restoring_divider_seq
// Purpose  : Scoreboard bench for restoring_divider_seq (WIDTH = 4). The
//            driver pushes reference results into a queue. A negedge monitor
//            pops and compares them whenever out_valid is presented.
// Revision : 1.0 - initial release
// ============================================================================
module tb_restoring_divider_seq;

    localparam int W = 4;
`ifdef DIVZERO_CHECK_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    restoring_divider_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           passes = 0;
    int           cyc    = 0;
    bit           holding = 1'b0;
    bit           rand_ready = 1'b0;
    logic [W-1:0] hq;
    logic [W-1:0] hr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: plain integer division; a zero divisor yields all ones and
    // the dividend as remainder, early only when the check is built in.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
        exp_t e;
        if (b == 0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = DZ;
            e.lat = DZ ? 1 : W;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
            e.lat = W;
        end
        e.acc = acc;
        return e;
    endfunction

    // Monitor
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            holding = 1'b0;
        end else if (out_valid) begin
            if (!holding) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_by_zero", div_by_zero, e.dbz);
                    chk("latency", cyc - e.acc, e.lat);
                    chk("in_ready_in_done", in_ready, 0);
                    hq      = quotient;
                    hr      = remainder;
                    holding = 1'b1;
                end
            end else begin
                chk("hold_quotient", quotient, hq);
                chk("hold_remainder", remainder, hr);
                chk("in_ready_in_done", in_ready, 0);
            end
            if (out_ready) holding = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #2;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int g = 0;
        @(negedge clk);
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        sb.push_back(model(a, b, cyc + 1));
        @(negedge clk);
        in_valid = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        chk("in_ready_after_accept", in_ready, 0);
    endtask

    task automatic drain();
        int g = 0;
        while ((sb.size() != 0 || holding || !in_ready) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst       = 1'b1;
        in_valid  = 1'b1;   // must be ignored while reset is held
        dividend  = 4'd7;
        divisor   = 4'd3;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_div_by_zero", div_by_zero, 0);

        // Basic divisions
        issue(4'd7, 4'd3);
        drain();
        issue(4'd10, 4'd5);
        issue(4'd15, 4'd1);
        issue(4'd3, 4'd7);
        drain();

        // Back-pressure: result must stay put while out_ready is low
        out_ready = 1'b0;
        issue(4'd13, 4'd2);
        g = 0;
        while (!out_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("bp_out_valid_seen", out_valid, 1);
        repeat (5) @(negedge clk);
        chk("bp_out_valid_held", out_valid, 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_after", in_ready, 1);
        chk("bp_out_valid_after", out_valid, 0);
        chk("keep_quotient_idle", quotient, 6);
        chk("keep_remainder_idle", remainder, 1);

        // Zero divisor
        issue(4'd9, 4'd0);
        drain();

        // Reset mid-RUN aborts the operation
        issue(4'd12, 4'd4);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete(sb.size() - 1);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_div_by_zero", div_by_zero, 0);
        issue(4'd12, 4'd4);
        drain();

        // Exhaustive sweep of nonzero divisors
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                issue(W'(a), W'(b));
            end
        end
        drain();

        // Random operands with random back-pressure, zero divisors included
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            issue(W'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) == 0) ? W'(0) : W'($urandom_range(1, 15)));
        end
        drain();
        rand_ready = 1'b0;
        @(posedge clk);
        #3;
        out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
